// File: rtl/mux_pkg.sv
// Shared encodings for the channel multiplexer/arbiter: arbitration modes and
// holding-register states.
package mux_pkg;

  typedef enum logic [1:0] {
    MODE_MAN = 2'b00,
    MODE_FIX = 2'b01,
    MODE_RR  = 2'b10
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating priority search: returns the first requesting index starting at ptr
// and wrapping modulo N. With ptr tied to zero it is a plain fixed priority.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SelW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SelW-1:0] ptr,
  output logic [SelW-1:0] gnt_idx,
  output logic            gnt_vld
);

  int idx;

  // NOTE: every output gets a default before the search loop, so no path
  // through this block can leave a value unassigned and infer a latch.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SelW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_arb.sv
// N-to-1 valid/ready multiplexer with manual, fixed-priority and round-robin
// arbitration feeding a one-entry output holding register.
module mux_arb
  import mux_pkg::*;
#(
  parameter int Size = 8,
  parameter int N    = 4,
  parameter int SelW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [SelW-1:0]   sel,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [N*Size-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Size-1:0]   out_data,
  output logic [SelW-1:0]   out_chan
);

  hold_state_e     state;
  logic [SelW-1:0] ptr;
  logic [SelW-1:0] arb_ptr;
  logic [SelW-1:0] arb_idx;
  logic            arb_vld;
  logic [SelW-1:0] gnt_idx;
  logic            gnt_vld;
  logic            load_en;
  logic            in_xfer;
  logic [Size-1:0] gnt_data;

  // Fixed priority is the rotating search anchored at channel 0.
  assign arb_ptr = (mode_e'(mode) == MODE_FIX) ? '0 : ptr;

  rr_arbiter #(.N(N), .SelW(SelW)) u_arb (
    .req     (in_valid),
    .ptr     (arb_ptr),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    gnt_idx = arb_idx;
    gnt_vld = arb_vld;
    if (mode_e'(mode) == MODE_MAN) begin
      gnt_idx = sel;
      gnt_vld = 1'b0;
      if (int'(sel) < N) gnt_vld = in_valid[sel];
    end
  end

  assign out_valid = (state == ST_FULL);
  assign load_en   = !out_valid || out_ready;
  // out_ready reaches in_ready only through load_en; reset blocks all acceptance.
  assign in_xfer   = !rst && load_en && gnt_vld;
  assign in_ready  = in_xfer ? (N'(1) << gnt_idx) : '0;
  assign gnt_data  = in_data[int'(gnt_idx)*Size +: Size];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_chan <= '0;
      ptr      <= '0;
    end else if (in_xfer) begin
      state    <= ST_FULL;
      out_data <= gnt_data;
      out_chan <= gnt_idx;
      ptr      <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end else if (out_valid && out_ready) begin
      state    <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb (N=4, Size=8): a vector table with out_ready held
// high, then hand-written stall, round-robin and reset sequences.
module tb_mux_arb;

  localparam int Size = 8;
  localparam int N    = 4;
  localparam int SelW = 2;

  logic              clk;
  logic              rst;
  logic [1:0]        mode;
  logic [SelW-1:0]   sel;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [N*Size-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [Size-1:0]   out_data;
  logic [SelW-1:0]   out_chan;

  int n_cmp = 0;
  int n_err = 0;

  mux_arb #(.Size(Size), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [31:0] data;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [7:0]  exp_data;
    logic [1:0]  exp_chan;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ch0=0x11 ch1=0x22 ch2=0x33 ch3=0x44 unless noted; ptr after each row in comment
    vecs[0]  = '{2'b01, 2'd0, 4'b1010, 32'h3300_1100, 4'b0010, 1'b1, 8'h11, 2'd1}; // ptr 2
    vecs[1]  = '{2'b01, 2'd0, 4'b0000, 32'h4433_2211, 4'b0000, 1'b0, 8'h00, 2'd0}; // ptr 2
    vecs[2]  = '{2'b00, 2'd2, 4'b1011, 32'h4433_2211, 4'b0000, 1'b0, 8'h00, 2'd0}; // ptr 2
    vecs[3]  = '{2'b00, 2'd2, 4'b0100, 32'h4433_2211, 4'b0100, 1'b1, 8'h33, 2'd2}; // ptr 3
    vecs[4]  = '{2'b00, 2'd3, 4'b0111, 32'h4433_2211, 4'b0000, 1'b0, 8'h00, 2'd0}; // ptr 3
    vecs[5]  = '{2'b10, 2'd0, 4'b1111, 32'h4433_2211, 4'b1000, 1'b1, 8'h44, 2'd3}; // ptr 0
    vecs[6]  = '{2'b10, 2'd0, 4'b1111, 32'h4433_2211, 4'b0001, 1'b1, 8'h11, 2'd0}; // ptr 1
    vecs[7]  = '{2'b11, 2'd0, 4'b1101, 32'h4433_2211, 4'b0100, 1'b1, 8'h33, 2'd2}; // ptr 3
    vecs[8]  = '{2'b01, 2'd1, 4'b1100, 32'h4433_2211, 4'b0100, 1'b1, 8'h33, 2'd2}; // ptr 3
    vecs[9]  = '{2'b10, 2'd0, 4'b0110, 32'h4433_2211, 4'b0010, 1'b1, 8'h22, 2'd1}; // ptr 2
    vecs[10] = '{2'b10, 2'd0, 4'b0011, 32'h4433_2211, 4'b0001, 1'b1, 8'h11, 2'd0}; // ptr 1

    // Reset with traffic offered: nothing accepted, outputs cleared.
    rst = 1'b1; mode = 2'b10; sel = '0; in_valid = 4'b1111;
    in_data = 32'h4433_2211; out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    step();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_chan", 32'(out_chan), 32'h0);
    check("rst_in_ready_held", 32'(in_ready), 32'h0);
    step();

    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      mode = vecs[i].mode; sel = vecs[i].sel; in_valid = vecs[i].iv;
      in_data = vecs[i].data; out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      step();
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) begin
        check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
        check($sformatf("vec%0d_out_chan", i), 32'(out_chan), 32'(vecs[i].exp_chan));
      end
    end

    // Round-robin over four always-valid channels from a fresh reset.
    rst = 1'b1; in_valid = '0;
    step();
    rst = 1'b0; mode = 2'b10; in_valid = 4'b1111; in_data = 32'h4433_2211; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr%0d_out_valid", i), 32'(out_valid), 32'h1);
      check($sformatf("rr%0d_out_chan", i), 32'(out_chan), 32'(i % 4));
    end

    // Stall: load 0x5A, hold three cycles while mode/sel wander, then resume.
    in_valid = '0;
    step();
    mode = 2'b01; in_valid = 4'b0001; in_data = 32'h0000_A55A; out_ready = 1'b0;
    #1;
    check("stall_load_in_ready", 32'(in_ready), 32'h1);
    step();
    check("stall_load_out_data", 32'(out_data), 32'h5A);
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      mode = 2'(i); sel = 2'd1;
      #1;
      check($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'h0);
      step();
      check($sformatf("stall%0d_out_valid", i), 32'(out_valid), 32'h1);
      check($sformatf("stall%0d_out_data", i), 32'(out_data), 32'h5A);
      check($sformatf("stall%0d_out_chan", i), 32'(out_chan), 32'h0);
    end
    mode = 2'b01; out_ready = 1'b1;
    #1;
    check("resume_in_ready", 32'(in_ready), 32'h2);
    step();
    check("resume_out_valid", 32'(out_valid), 32'h1);
    check("resume_out_data", 32'(out_data), 32'hA5);
    check("resume_out_chan", 32'(out_chan), 32'h1);

    // Reset while FULL with ptr=2: data dropped, round-robin restarts at 0.
    rst = 1'b1; mode = 2'b10; in_valid = 4'b1111; in_data = 32'h4433_2211; out_ready = 1'b1;
    #1;
    check("full_rst_in_ready", 32'(in_ready), 32'h0);
    step();
    check("full_rst_out_valid", 32'(out_valid), 32'h0);
    check("full_rst_out_data", 32'(out_data), 32'h0);
    check("full_rst_out_chan", 32'(out_chan), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    step();
    check("post_rst_out_chan", 32'(out_chan), 32'h0);
    check("post_rst_out_data", 32'(out_data), 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter Size, default 8: data width per channel, in bits.
REQ-002 Parameter N, default 4: number of input channels; legal range 2..16.
REQ-003 Derived constant SelW = clog2(N): width of channel indices.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mode  input  2  arbitration mode: 00 manual, 01 fixed priority, 10 round-robin, 11 treated as 10.
REQ-007 sel  input  SelW  channel index used in manual mode.
REQ-008 in_valid  input  N  bit k high: channel k offers data.
REQ-009 in_ready  output  N  bit k high: channel k is accepted this cycle if valid.
REQ-010 in_data  input  N*Size  channel k data at bits [k*Size +: Size].
REQ-011 out_valid  output  1  holding register contains data.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 out_data  output  Size  registered data of the selected channel.
REQ-014 out_chan  output  SelW  index of the channel that out_data came from.

Function
REQ-015 The block SHALL contain a one-entry output holding register with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en SHALL be high when the register is EMPTY, or when it is FULL and out_ready=1.
REQ-017 The grant SHALL be computed combinationally from in_valid, mode, sel and the round-robin pointer ptr, as follows:
- manual: grant=sel if in_valid[sel]; no grant if sel>=N or in_valid[sel]=0.
- fixed: the lowest-index k with in_valid[k]=1.
- round-robin: the first k with in_valid[k]=1, searching ptr, ptr+1, ..., wrapping modulo N.
REQ-018 in_ready[k] SHALL equal load_en AND (a grant exists) AND (grant==k); at most one bit is high per cycle (one-hot or zero).
REQ-019 in_ready SHALL NOT depend on in_valid of ungranted channels through any combinational path to out_ready other than via load_en.
REQ-020 An input transfer on channel k (in_valid[k] & in_ready[k]) SHALL load in_data[k] into out_data and k into out_chan, and set FULL at the next edge; latency 1 cycle.
REQ-021 An output transfer (out_valid & out_ready) with no simultaneous input transfer SHALL move the register to EMPTY.
REQ-022 Simultaneous output and input transfers SHALL keep the register FULL with the new data, sustaining 1 transfer per cycle.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_chan SHALL hold stable and all in_ready bits SHALL be 0.
REQ-024 On every input transfer from channel k, in any mode, ptr SHALL become (k+1) mod N; otherwise ptr holds its value.
REQ-025 A change of mode or sel SHALL affect only the arbitration of the current cycle and later cycles, and SHALL never alter data already in the holding register.
REQ-026 When no in_valid bit is set, no transfer SHALL occur and ptr SHALL hold its value.

Reset
REQ-027 When rst=1 at a clock edge: out_valid=0, out_data=0, out_chan=0, ptr=0.
REQ-028 While rst=1, in_ready SHALL be all zeros; data presented during reset SHALL be discarded.
REQ-029 A reset asserted while FULL SHALL drop the held data without an output transfer.

Structure
REQ-030 The mode encodings (MODE_MAN, MODE_FIX, MODE_RR) SHALL be defined once in the shared package mux_pkg.
REQ-031 The round-robin/priority search SHALL be a sub-module, rr_arbiter (inputs req[N], ptr; outputs gnt_idx, gnt_vld); fixed priority SHALL use it with ptr=0.

Verification
REQ-032 N=4, Size=8, mode=01, in_valid=1010, data ch1=0x11 and ch3=0x33, out_ready=1 -> in_ready=0010; next cycle out_data=0x11, out_chan=1.
REQ-033 mode=10, in_valid=1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 mode=00, sel=2, in_valid=1011 -> in_ready=0000; then in_valid=0100 -> in_ready=0100, out_chan=2 one cycle later.
REQ-035 FULL with 0x5A, out_ready=0 for 3 cycles -> out_data=0x5A stable, in_ready=0000; then out_ready=1 with a pending input -> new data is loaded with no bubble.
REQ-036 rst=1 asserted while FULL, with ptr=2 -> next cycle out_valid=0, out_data=0, out_chan=0; round-robin restarts at channel 0.
